// File: rtl/bin_to_bcd_display.sv
// Binary-to-BCD converter (double dabble) with leading-zero blanking and halt code for the 7-segment digits.
// Latency: WIDTH+1 cycles from accepted start to done; halt requests complete on the accepting edge.
// Backpressure: none; start is ignored while busy, and bcd_o holds until the next completion.
module bin_to_bcd_display #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      value_i,
    input  logic                  halt_i,
    input  logic                  blank_zeros_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int AW         = 4 * DIGITS;
    localparam int CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [3:0]    BLANK_CODE = 4'hE;
    localparam logic [3:0]    HALT_CODE  = 4'hF;

    generate
        if (DIGITS < MIN_DIGITS || WIDTH < 2) begin : g_bad_cfg
            $error("bin_to_bcd_display: DIGITS too small for WIDTH, or WIDTH < 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_BLANK
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              blank_q, blank_d;
    logic [AW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;

    logic [AW-1:0]     acc_adj;
    logic [AW-1:0]     disp;
    logic              leading;

    // Add-3 correction so each digit carries correctly into the next after the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Blank zeros from the top down until the first nonzero; digit 0 always shows.
    always_comb begin
        disp    = acc_q;
        leading = blank_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (acc_q[4*i +: 4] == 4'd0)) begin
                disp[4*i +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        blank_d = blank_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (halt_i) begin
                        bcd_d  = {DIGITS{HALT_CODE}};
                        done_d = 1'b1;
                    end else begin
                        sr_d    = value_i;
                        blank_d = blank_zeros_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = {acc_adj[AW-2:0], sr_q[WIDTH-1]};
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                bcd_d   = disp;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            bcd_q   <= {DIGITS{BLANK_CODE}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            blank_q <= blank_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;

    a_busy_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(busy_o && done_o));

endmodule

// File: doc/bin_to_bcd_display.md
# bin_to_bcd_display

Sequential binary-to-BCD converter that produces the digit codes consumed by the per-digit 7-segment decoders on the board display. It accepts a binary value from the processor output path on a start strobe and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then applies optional leading-zero blanking and presents all digits at once in a held register. A halt request bypasses conversion and drives every digit to the halt code, which the decoders render as "H".

## Interface
- WIDTH, 16: bit width of the binary input.
- DIGITS, 5: number of BCD digits output; must be ≥ ceil(WIDTH·0.30103); smaller values are an illegal configuration.
- Clock  input  1  rising-edge clock, the only clock.
- Reset  input  1  synchronous, active-low reset (sampled on Clock rising edge; 0 = reset).
- start  input  1  request conversion; sampled only in IDLE.
- value  input  WIDTH  unsigned binary value; captured on the accepting edge.
- halt  input  1  sampled with start; 1 = show halt code instead of converting.
- blank_zeros  input  1  sampled with start; 1 = blank leading zeros.
- bcd  output  4·DIGITS  digit codes, digit 0 (least significant) in bits [3:0]; registered, updated only on completion.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has just been updated.

## Operation
- Digit codes: 4'h0–4'h9 decimal; 4'hE blank (decoder lights no segments); 4'hF halt.
- FSM states: IDLE, SHIFT, BLANK.
- IDLE, start=1, halt=1: bcd ← all 4'hF, done pulses, state stays IDLE, busy stays 0. Halt has priority over conversion.
- IDLE, start=1, halt=0: capture value into shift register, latch blank_zeros, clear BCD accumulator, bit counter ← 0, go to SHIFT.
- SHIFT: per cycle, every accumulator digit ≥ 5 gets +3, then {accumulator, shift register} shifts left by 1. After WIDTH shifts, go to BLANK.
- BLANK: if the latched blank_zeros=1, scan from the most significant digit down and replace each 0 with 4'hE until the first nonzero digit. Digit 0 is never blanked, so value 0 displays "0". Load bcd, pulse done, return to IDLE.
- start while busy is ignored; inputs are not re-sampled mid-conversion.
- bcd holds its last value indefinitely until the next completion.
- Reset (Reset=0 at an edge): state IDLE, bcd = all 4'hE, busy=0, done=0, internal registers cleared. Reset mid-conversion aborts silently: no done, bcd unchanged from the reset value.

## Timing
- Let E0 be the edge at which start is accepted in IDLE.
- Conversion path: busy=1 after E0. Shifts occur at edges E1..E_WIDTH. At E_{WIDTH+1}, bcd is loaded, done=1 and busy=0. done falls at E_{WIDTH+2}.
- Latency from start to done is WIDTH+1 cycles (17 for the default).
- Throughput: the next start can be accepted at E_{WIDTH+2}, one conversion per WIDTH+2 cycles. start may be held high continuously.
- Halt path: bcd and done update at E0 itself. done is high for the cycle after E0 only.
- done is never high for more than one consecutive cycle unless back-to-back halt requests are accepted.
- busy and done are never high in the same cycle.

## Test plan
- Reset: hold Reset=0 for 2 edges -> bcd=20'hEEEEE, busy=0, done=0. Then release and keep start=0 for 30 cycles -> outputs unchanged.
- Basic conversion: value=16'd12345, blank_zeros=0, start pulse at E0 -> busy 1 for E1..E16, done=1 exactly after E17, bcd=20'h12345. Extreme values: 65535 -> 20'h65535, 0 -> 20'h00000.
- Blanking: value=42, blank_zeros=1 -> bcd=20'hEEE42. Value=0, blank_zeros=1 -> 20'hEEEE0. Value=10005, blank_zeros=1 -> 20'h10005 (interior zeros kept).
- Halt: halt=1, start=1 with value=999 -> bcd=20'hFFFFF and done high the cycle after E0, busy never high. A following normal start with value=7 -> 20'h00007.
- Busy/back-to-back: start held high, value changed to 321 at E5 of a conversion of 100 -> first result is 20'h00100. Second acceptance happens at E18, giving 20'h00321 at E35.
- Reset mid-operation: Reset=0 at E8 of a conversion -> no done pulse, bcd=20'hEEEEE, busy=0. A new start then converts normally.
